// File: rtl/sample_frame_collector_pkg.sv
// Shared constants and types for the sample frame collector.
//   SAMPLE_SIZE  : default width of one signed time-domain sample
//   BUFFER_SIZE  : default samples per frame (power of two, >= 2)
//   bank_state_e : occupancy state of one ping-pong frame bank
package sample_frame_collector_pkg;

  localparam int SAMPLE_SIZE = 16;
  localparam int BUFFER_SIZE = 8;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

endpackage

// File: rtl/sample_frame_collector_if.sv
// Sample-in / frame-out bus of the frame collector.
//   in_sample, in_valid, in_ready        : sample stream (valid/ready)
//   frame_bitstream, frame_valid,
//   frame_ready                          : assembled frame stream (valid/ready)
//   overrun_count                        : saturating count of refused samples
// slave modport is the collector, master modport is the sample source/frame sink.
interface sample_frame_collector_if
  import sample_frame_collector_pkg::*;
#(
  parameter int sample_size = SAMPLE_SIZE,
  parameter int buffer_size = BUFFER_SIZE
) ();

  logic signed [sample_size-1:0]             in_sample;
  logic                                      in_valid;
  logic                                      in_ready;
  logic        [buffer_size*sample_size-1:0] frame_bitstream;
  logic                                      frame_valid;
  logic                                      frame_ready;
  logic        [15:0]                        overrun_count;

  modport slave (
    input  in_sample, in_valid, frame_ready,
    output in_ready, frame_bitstream, frame_valid, overrun_count
  );

  modport master (
    output in_sample, in_valid, frame_ready,
    input  in_ready, frame_bitstream, frame_valid, overrun_count
  );

endinterface

// File: rtl/sample_frame_collector_bank.sv
// frame_bank: one ping-pong bank holding a full frame.
//   clk, reset : clock, synchronous active-high reset (state only)
//   wr_en      : store wr_data at slot wr_idx this edge
//   wr_last    : the write is the final slot of the frame
//   wr_idx     : slot index, slot k occupies bits [k*sample_size +: sample_size]
//   wr_data    : sample to store, copied bit-exact
//   rd_take    : downstream consumed this bank's frame this edge
//   state      : EMPTY / FILLING / FULL
//   data       : bank contents
module frame_bank
  import sample_frame_collector_pkg::*;
#(
  parameter int sample_size = SAMPLE_SIZE,
  parameter int buffer_size = BUFFER_SIZE,
  parameter int idx_w       = $clog2(buffer_size)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                wr_en,
  input  logic                                wr_last,
  input  logic        [idx_w-1:0]             wr_idx,
  input  logic signed [sample_size-1:0]       wr_data,
  input  logic                                rd_take,
  output bank_state_e                         state,
  output logic [buffer_size*sample_size-1:0]  data
);

  // Writes only happen while not FULL and takes only while FULL, so the two
  // never coincide on one bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BANK_EMPTY;
    end else if (rd_take) begin
      state <= BANK_EMPTY;
    end else if (wr_en) begin
      state <= wr_last ? BANK_FULL : BANK_FILLING;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data[wr_idx*sample_size +: sample_size] <= wr_data;
    end
  end

endmodule

// File: rtl/sample_frame_collector.sv
// sample_frame_collector: packs a stream of signed samples into frames of
// buffer_size samples using two ping-pong banks, so one frame can be filled
// while the previous one waits for the downstream FFT.
//   clk, reset : clock, synchronous active-high reset
//   bus        : sample_frame_collector_if.slave (sample in, frame out,
//                overrun counter)
module sample_frame_collector
  import sample_frame_collector_pkg::*;
#(
  parameter int sample_size = SAMPLE_SIZE,
  parameter int buffer_size = BUFFER_SIZE
) (
  input  logic                      clk,
  input  logic                      reset,
  sample_frame_collector_if.slave   bus
);

  localparam int IDX_W   = $clog2(buffer_size);
  localparam int FRAME_W = buffer_size * sample_size;

  logic [IDX_W-1:0]   wr_idx;
  logic               fill_sel;
  logic               rd_sel;
  logic [15:0]        overrun;
  bank_state_e        state0, state1;
  logic [FRAME_W-1:0] data0, data1;
  logic               fill_full, rd_full, accept, take, last;

  // Handshake decisions come only from registered bank state, never from
  // in_valid, so in_ready has no combinational path from the source.
  always_comb begin
    fill_full = fill_sel ? (state1 == BANK_FULL) : (state0 == BANK_FULL);
    rd_full   = rd_sel   ? (state1 == BANK_FULL) : (state0 == BANK_FULL);
    accept    = bus.in_valid & ~fill_full;
    take      = rd_full & bus.frame_ready;
    last      = (wr_idx == IDX_W'(buffer_size - 1));
  end

  assign bus.in_ready        = ~fill_full;
  assign bus.frame_valid     = rd_full;
  assign bus.frame_bitstream = rd_sel ? data1 : data0;
  assign bus.overrun_count   = overrun;

  frame_bank #(
    .sample_size (sample_size),
    .buffer_size (buffer_size),
    .idx_w       (IDX_W)
  ) u_bank0 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept & ~fill_sel),
    .wr_last (last),
    .wr_idx  (wr_idx),
    .wr_data (bus.in_sample),
    .rd_take (take & ~rd_sel),
    .state   (state0),
    .data    (data0)
  );

  frame_bank #(
    .sample_size (sample_size),
    .buffer_size (buffer_size),
    .idx_w       (IDX_W)
  ) u_bank1 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept & fill_sel),
    .wr_last (last),
    .wr_idx  (wr_idx),
    .wr_data (bus.in_sample),
    .rd_take (take & rd_sel),
    .state   (state1),
    .data    (data1)
  );

  // Write index, bank pointers and overrun counter. The fill pointer flips on
  // the edge that writes the last slot; the read pointer flips on a take.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx   <= '0;
      fill_sel <= 1'b0;
      rd_sel   <= 1'b0;
      overrun  <= '0;
    end else begin
      if (accept) begin
        wr_idx <= last ? '0 : wr_idx + 1'b1;
        if (last) begin
          fill_sel <= ~fill_sel;
        end
      end
      if (take) begin
        rd_sel <= ~rd_sel;
      end
      if (bus.in_valid && fill_full && overrun != 16'hFFFF) begin
        overrun <= overrun + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sample_frame_collector.sv
module tb_sample_frame_collector;
  import sample_frame_collector_pkg::*;

  localparam int SW = 16;
  localparam int BN = 8;
  localparam int FW = SW * BN;

  logic clk = 1'b0;
  logic reset;

  sample_frame_collector_if #(.sample_size(SW), .buffer_size(BN)) bus ();

  sample_frame_collector #(.sample_size(SW), .buffer_size(BN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: completed frames waiting downstream plus one partial frame.
  logic [FW-1:0] full_q[$];
  logic [FW-1:0] part;
  int            part_n = 0;
  int            ovr    = 0;
  bit            live   = 0;

  always @(posedge clk) begin
    if (reset) begin
      full_q.delete();
      part_n = 0;
      ovr    = 0;
      live   = 1;
    end else if (live) begin
      bit acc, tk;
      acc = bus.in_valid && (full_q.size() < 2);
      tk  = bus.frame_ready && (full_q.size() >= 1);
      if (bus.in_valid && !(full_q.size() < 2) && ovr < 65535) ovr++;
      if (tk) void'(full_q.pop_front());
      if (acc) begin
        part[part_n*SW +: SW] = bus.in_sample;
        part_n++;
        if (part_n == BN) begin
          full_q.push_back(part);
          part_n = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("cmp_in_ready", FW'(bus.in_ready), FW'(full_q.size() < 2));
      chk("cmp_frame_valid", FW'(bus.frame_valid), FW'(full_q.size() >= 1));
      chk("cmp_overrun", FW'(bus.overrun_count), FW'(ovr));
      if (full_q.size() >= 1) chk("cmp_frame_data", bus.frame_bitstream, full_q[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic send(input logic [SW-1:0] v);
    bus.in_valid  = 1'b1;
    bus.in_sample = v;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sample = '0;
    bus.frame_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", FW'(bus.in_ready), FW'(1));
    chk("rst_frame_valid", FW'(bus.frame_valid), FW'(0));
    chk("rst_overrun", FW'(bus.overrun_count), FW'(0));
    reset = 1'b0;

    // Samples 1..8, frame valid one cycle after the last sample
    bus.frame_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(SW'(i));
      if (i == 7) chk("t1_not_yet_valid", FW'(bus.frame_valid), FW'(0));
    end
    chk("t1_frame_valid", FW'(bus.frame_valid), FW'(1));
    chk("t1_low_sample", FW'(bus.frame_bitstream[15:0]), FW'(16'd1));
    chk("t1_high_sample", FW'(bus.frame_bitstream[127:112]), FW'(16'd8));
    chk("t1_frame", bus.frame_bitstream, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    tick();
    chk("t1_consumed", FW'(bus.frame_valid), FW'(0));

    // Both banks full, overruns, then back-to-back frames
    do_reset();
    bus.frame_ready = 1'b0;
    for (int i = 1; i <= 16; i++) send(SW'(i));
    chk("t2_in_ready_low", FW'(bus.in_ready), FW'(0));
    bus.in_valid  = 1'b1;
    bus.in_sample = 16'h0099;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    chk("t2_overrun3", FW'(bus.overrun_count), FW'(3));
    chk("t2_frame_a", bus.frame_bitstream, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    bus.frame_ready = 1'b1;
    tick();
    chk("t2_still_valid", FW'(bus.frame_valid), FW'(1));
    chk("t2_frame_b", bus.frame_bitstream, 128'h0010_000F_000E_000D_000C_000B_000A_0009);
    chk("t2_in_ready_back", FW'(bus.in_ready), FW'(1));
    tick();
    chk("t2_drained", FW'(bus.frame_valid), FW'(0));
    bus.frame_ready = 1'b0;

    // Last sample of bank 1 accepted on the edge bank 0 transfers
    do_reset();
    for (int i = 0; i < 8; i++) send(SW'(16'h0011 + i));
    for (int i = 0; i < 7; i++) send(SW'(16'h0021 + i));
    bus.in_valid    = 1'b1;
    bus.in_sample   = 16'h0028;
    bus.frame_ready = 1'b1;
    chk("t3_no_stall", FW'(bus.in_ready), FW'(1));
    chk("t3_frame0", bus.frame_bitstream, 128'h0018_0017_0016_0015_0014_0013_0012_0011);
    tick();
    bus.in_valid = 1'b0;
    chk("t3_valid_kept", FW'(bus.frame_valid), FW'(1));
    chk("t3_in_ready", FW'(bus.in_ready), FW'(1));
    chk("t3_frame1", bus.frame_bitstream, 128'h0028_0027_0026_0025_0024_0023_0022_0021);
    tick();
    chk("t3_drained", FW'(bus.frame_valid), FW'(0));
    bus.frame_ready = 1'b0;

    // Reset discards a partial frame
    do_reset();
    for (int i = 1; i <= 5; i++) send(SW'(i));
    do_reset();
    chk("t4_after_reset", FW'(bus.frame_valid), FW'(0));
    for (int i = 100; i <= 107; i++) send(SW'(i));
    chk("t4_frame", bus.frame_bitstream, 128'h006B_006A_0069_0068_0067_0066_0065_0064);
    bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;

    // Negative and extreme samples stored bit-exact
    send(16'h8000); send(16'hFFFF); send(16'h7FFF); send(16'h0001);
    send(16'h8001); send(16'hFFFE); send(16'h0000); send(16'hC000);
    chk("t5_frame", bus.frame_bitstream, 128'hC000_0000_FFFE_8001_0001_7FFF_FFFF_8000);
    bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;

    // Overrun counter saturation
    do_reset();
    for (int i = 1; i <= 16; i++) send(SW'(i));
    bus.in_valid  = 1'b1;
    bus.in_sample = 16'h0055;
    repeat (65540) tick();
    bus.in_valid = 1'b0;
    chk("t6_saturated", FW'(bus.overrun_count), FW'(16'hFFFF));
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_frame_collector.md
SAMPLE_FRAME_COLLECTOR -- requirements
Module: sample_frame_collector

Interface
REQ-001 SHALL have parameter sample_size, default SAMPLE_SIZE, width in bits of one signed time-domain sample.
REQ-002 SHALL have parameter buffer_size, default BUFFER_SIZE, samples per frame; power of two, at least 2.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_sample  input  sample_size  signed audio sample.
REQ-007 in_valid  input  1  in_sample is valid this cycle.
REQ-008 in_ready  output  1  collector can accept a sample this cycle.
REQ-009 frame_bitstream  output  buffer_size*sample_size  assembled frame, feeding the FFT input_bitstream.
REQ-010 frame_valid  output  1  frame_bitstream holds a complete frame.
REQ-011 frame_ready  input  1  downstream consumes the frame this cycle.
REQ-012 overrun_count  output  16  saturating count of cycles with in_valid=1 and in_ready=0.

Function
REQ-013 A sample SHALL transfer when in_valid and in_ready are both high on a rising clk edge.
REQ-014 A frame SHALL transfer when frame_valid and frame_ready are both high on a rising clk edge.
REQ-015 Storage SHALL be two frame banks (ping-pong): a fill bank and a read bank.
REQ-016 Each bank SHALL have state EMPTY, FILLING or FULL.
REQ-016a EMPTY -> FILLING on the first accepted sample.
REQ-016b FILLING -> FULL on acceptance of sample buffer_size-1.
REQ-016c FULL -> EMPTY on frame transfer from that bank.
REQ-017 The k-th accepted sample of a frame (k = 0..buffer_size-1) SHALL occupy bits [k*sample_size +: sample_size].
REQ-018 The write index SHALL wrap from buffer_size-1 to 0, and the fill bank SHALL toggle on the same edge.
REQ-019 in_ready SHALL be high iff the current fill bank is not FULL; it is combinational from registered state only, with no dependence on in_valid.
REQ-020 frame_valid SHALL be high iff the read bank is FULL, and SHALL rise on the cycle after the edge that accepts the last sample (latency 1).
REQ-021 frame_bitstream SHALL equal the read bank contents, held stable while frame_valid=1 and the frame is not transferred.
REQ-022 After a frame transfer, the read bank SHALL toggle; frame_valid stays high next cycle if the other bank is FULL.
REQ-023 With both banks FULL, in_ready SHALL be 0 and no sample SHALL be lost or overwritten.
REQ-024 If, on the same edge, the last sample of bank A is accepted and bank B transfers, both transitions SHALL occur and in_ready SHALL remain 1.
REQ-025 Samples SHALL be stored bit-exact; no arithmetic or sign change SHALL be applied.
REQ-026 overrun_count SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-027 frame_bitstream SHALL be don't-care while frame_valid=0, and the bench SHALL NOT check it then.

Reset
REQ-028 On reset, both banks SHALL go to EMPTY, write index to 0 and both bank pointers to bank 0.
REQ-029 On reset, outputs SHALL be in_ready=1, frame_valid=0 and overrun_count=0.
REQ-030 Reset SHALL take priority over any same-cycle transfer.
REQ-031 A partially filled frame SHALL be discarded by reset mid-operation.
REQ-032 Bank data registers SHALL NOT require reset.

Structure
REQ-033 SAMPLE_SIZE, BUFFER_SIZE and the bank-state enum type SHALL reside in the shared constants package.
REQ-034 One sub-module, frame_bank, SHALL hold one bank (storage, state, indexed write); it SHALL be instantiated twice.

Verification
REQ-035 The bench SHALL drive buffer_size=8, sample_size=16, and samples 1..8 with frame_ready=1. Required response: frame_valid=1 exactly one cycle after sample 8; bits[15:0]=1 and bits[127:112]=8.
REQ-036 The bench SHALL hold frame_ready=0 and drive 16 samples then 3 more. Required response: in_ready=0 after sample 16, and overrun_count=3.
REQ-037 Following REQ-036, the bench SHALL raise frame_ready. Required response: two back-to-back frames (samples 1..8, then 9..16) on consecutive cycles.
REQ-038 The bench SHALL accept the sample completing bank 1 on the same edge that bank 0 transfers. Required response: no stall, frame_valid stays 1, data = bank 1.
REQ-039 The bench SHALL assert reset after 5 of 8 samples, then drive samples 100..107. Required response: the first frame is exactly 100..107.
REQ-040 The bench SHALL drive negative samples (16'h8000, 16'hFFFF). Required response: they appear bit-exact in frame_bitstream.
